// File: rtl/pattern_det_sched.sv
// Round-robin scheduler sharing one BBCBC detector across NLANES sensor lanes.
// Each lane keeps its own match progress, so interleaved streams are detected
// independently. Matches are reported with the lane ID, and every lane has a
// saturating match counter that can be read back by lane index.
module pattern_det_sched #(
    parameter int unsigned NLANES = 4,
    parameter int unsigned LANE_W = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [NLANES-1:0] req,
    input  logic [NLANES-1:0] sym,
    output logic [NLANES-1:0] gnt,
    output logic              match_vld,
    output logic [LANE_W-1:0] match_lane,
    input  logic [LANE_W-1:0] rd_lane,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int unsigned ST_W = 3;

    // Detector progress: S1 = "B", S2 = "BB", S3 = "BBC", S4 = "BBCB"
    typedef enum logic [ST_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [LANE_W-1:0] LANE_TOP = LANE_W'(NLANES - 1);

    // Registered state
    logic [LANE_W-1:0] r_ptr;
    logic [ST_W-1:0]   r_state [NLANES];
    logic [CNT_W-1:0]  r_cnt   [NLANES];
    logic              r_match_vld;
    logic [LANE_W-1:0] r_match_lane;
    logic [CNT_W-1:0]  r_rd_cnt;

    // Combinational datapath
    logic [NLANES-1:0] w_gnt;
    logic              w_gnt_any;
    logic [LANE_W-1:0] w_gnt_idx;
    logic [LANE_W-1:0] w_ptr_nxt;
    logic              w_sym;
    logic [ST_W-1:0]   w_cur;
    det_state_t        w_nxt;
    logic              w_hit;
    logic [CNT_W-1:0]  w_rd_val;

    // Lane index reached by stepping 'off' lanes forward from 'base', wrapping at NLANES
    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] base,
                                                   input int unsigned       off);
        int unsigned sum;
        sum = (32'(base) + off) % NLANES;
        return LANE_W'(sum);
    endfunction

    // Round-robin grant: first requesting lane at or after the pointer
    always_comb begin
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (rst && en && !clr) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                if (!w_gnt_any && req[lane_add(r_ptr, i)]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = lane_add(r_ptr, i);
                end
            end
            if (w_gnt_any) begin
                w_gnt[w_gnt_idx] = 1'b1;
            end
        end
    end

    // Pointer advances to the lane after the one just granted
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_gnt_any) begin
            w_ptr_nxt = (w_gnt_idx == LANE_TOP) ? '0 : w_gnt_idx + LANE_W'(1);
        end
    end

    // Route the granted lane's symbol and stored progress into the shared engine
    always_comb begin
        w_sym = 1'b0;
        w_cur = S0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (w_gnt[i]) begin
                w_sym = sym[i];
                w_cur = r_state[i];
            end
        end
    end

    // Shared BBCBC next-state logic; sym 0 = B, 1 = C
    always_comb begin
        w_nxt = S0;
        w_hit = 1'b0;
        case (w_cur)
            S0: w_nxt = w_sym ? S0 : S1;
            S1: w_nxt = w_sym ? S0 : S2;
            S2: w_nxt = w_sym ? S3 : S2;
            S3: w_nxt = w_sym ? S0 : S4;
            S4: begin
                if (w_sym) begin
                    w_nxt = S0;
                    w_hit = 1'b1;
                end else begin
                    w_nxt = S2;
                end
            end
            default: w_nxt = S0;
        endcase
    end

    // Counter read mux; out-of-range lane indices read as zero
    always_comb begin
        w_rd_val = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (rd_lane == LANE_W'(i)) begin
                w_rd_val = r_cnt[i];
            end
        end
    end

    // Round-robin pointer; kept across clr, held when nothing is granted
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Per-lane detector progress; only the granted lane moves
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                r_state[i] <= S0;
            end
        end else begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                if (w_gnt[i]) begin
                    r_state[i] <= w_nxt;
                end
            end
        end
    end

    // Per-lane saturating match counters
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                if (w_gnt[i] && w_hit && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Match report: one-cycle pulse with the lane ID; clr squashes it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_match_vld  <= 1'b0;
            r_match_lane <= '0;
        end else if (clr) begin
            r_match_vld  <= 1'b0;
        end else begin
            r_match_vld <= w_gnt_any && w_hit;
            if (w_gnt_any && w_hit) begin
                r_match_lane <= w_gnt_idx;
            end
        end
    end

    // Registered counter read, showing the pre-increment value
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_cnt <= '0;
        end else begin
            r_rd_cnt <= w_rd_val;
        end
    end

    assign gnt        = w_gnt;
    assign match_vld  = r_match_vld;
    assign match_lane = r_match_lane;
    assign rd_cnt     = r_rd_cnt;

endmodule

// File: tb/tb_pattern_det_sched.sv
// Bench for pattern_det_sched: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a history-based reference model.
module tb_pattern_det_sched;

    localparam int unsigned NLANES = 4;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en  = 1'b1;
    logic              clr = 1'b0;
    logic [NLANES-1:0] req = '0;
    logic [NLANES-1:0] sym = '0;
    logic [NLANES-1:0] gnt;
    logic              match_vld;
    logic [LANE_W-1:0] match_lane;
    logic [LANE_W-1:0] rd_lane = '0;
    logic [CNT_W-1:0]  rd_cnt;

    pattern_det_sched #(.NLANES(NLANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .sym(sym),
        .gnt(gnt), .match_vld(match_vld), .match_lane(match_lane),
        .rd_lane(rd_lane), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: symbol history since the last match, counts, RR pointer
    int          m_ptr = 0;
    logic [4:0]  m_hist [NLANES];
    int          m_len  [NLANES];
    int          m_cnt  [NLANES];
    logic [NLANES-1:0] exp_gnt = '0;
    logic        exp_mv = 1'b0;
    int          exp_ml = 0;
    int          exp_rd = 0;

    int n_match [NLANES];
    int n_mv = 0;
    int wait_cyc [NLANES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NLANES; i++) begin
            m_hist[i] = '0;
            m_len[i]  = 0;
            m_cnt[i]  = 0;
        end
    endtask

    // Grant seen by the model for the current inputs
    task automatic model_gnt();
        exp_gnt = '0;
        if (rst && en && !clr) begin
            for (int i = 0; i < NLANES; i++) begin
                int l;
                l = (m_ptr + i) % NLANES;
                if (exp_gnt == '0 && req[l]) exp_gnt[l] = 1'b1;
            end
        end
    endtask

    // Model state update for the coming clock edge
    task automatic model_edge();
        if (!rst) begin
            model_clear();
            m_ptr  = 0;
            exp_mv = 1'b0;
            exp_ml = 0;
            exp_rd = 0;
        end else begin
            exp_rd = (int'(rd_lane) < NLANES) ? m_cnt[rd_lane] : 0;
            exp_mv = 1'b0;
            if (clr) begin
                model_clear();
            end else if (exp_gnt != '0) begin
                int k;
                k = 0;
                for (int i = 0; i < NLANES; i++) if (exp_gnt[i]) k = i;
                m_hist[k] = {m_hist[k][3:0], sym[k]};
                m_len[k]++;
                // B B C B C, oldest first, with 0 = B and 1 = C
                if (m_len[k] >= 5 && m_hist[k] == 5'b00101) begin
                    exp_mv = 1'b1;
                    exp_ml = k;
                    if (m_cnt[k] < CMAX) m_cnt[k]++;
                    m_len[k] = 0;
                end
                m_ptr = (k + 1) % NLANES;
            end
        end
    endtask

    // One clock: check grant mid-cycle, then registered outputs after the edge
    task automatic tick();
        @(negedge clk);
        model_gnt();
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        model_edge();
        @(posedge clk);
        #1;
        chk("match_vld", 32'(match_vld), 32'(exp_mv));
        if (exp_mv) chk("match_lane", 32'(match_lane), 32'(exp_ml));
        chk("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
        if (match_vld === 1'b1) begin
            n_mv++;
            n_match[match_lane]++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        en  = 1'b1;
        clr = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Feed 'n' symbols (MSB first) to a single lane, one per cycle
    task automatic send_lane(input int lane, input logic [15:0] bits, input int n);
        for (int j = 0; j < n; j++) begin
            req       = '0;
            req[lane] = 1'b1;
            sym[lane] = bits[n-1-j];
            tick();
        end
        req = '0;
    endtask

    initial begin
        int base;
        int first_lane;
        int idx [NLANES];
        logic [9:0] pat;

        model_clear();
        for (int i = 0; i < NLANES; i++) begin
            n_match[i]  = 0;
            wait_cyc[i] = 0;
        end

        // Reset values
        do_reset();
        chk("rst_match_vld", 32'(match_vld), 32'd0);
        chk("rst_match_lane", 32'(match_lane), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);

        // Single lane 0: BBCBC
        send_lane(0, 16'b00101, 5);
        chk("l0_match_cnt", 32'(n_match[0]), 32'd1);
        rd_lane = 2'd0;
        tick();
        chk("l0_rd_cnt", 32'(rd_cnt), 32'd1);

        // Lanes 0 and 2 interleave BBCBC
        do_reset();
        for (int i = 0; i < NLANES; i++) begin
            n_match[i] = 0;
            idx[i]     = 0;
        end
        first_lane = -1;
        pat = 10'b0000000101;
        req = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            sym[0] = pat[4 - idx[0]];
            sym[2] = pat[4 - idx[2]];
            #1;
            chk("alt_gnt", 32'(gnt), (c % 2 == 0) ? 32'h1 : 32'h4);
            tick();
            if (exp_gnt[0]) idx[0]++;
            if (exp_gnt[2]) idx[2]++;
            if (match_vld === 1'b1 && first_lane < 0) first_lane = int'(match_lane);
            if (idx[0] == 5) req[0] = 1'b0;
            if (idx[2] == 5) req[2] = 1'b0;
        end
        req = '0;
        chk("alt_first_lane", 32'(first_lane), 32'd0);
        chk("alt_m0", 32'(n_match[0]), 32'd1);
        chk("alt_m2", 32'(n_match[2]), 32'd1);
        for (int l = 0; l < NLANES; l++) begin
            rd_lane = LANE_W'(l);
            tick();
            chk("alt_cnt", 32'(rd_cnt), (l == 0 || l == 2) ? 32'd1 : 32'd0);
        end

        // Lane 1: S2 self-loop and restart after match
        do_reset();
        base = n_match[1];
        send_lane(1, 16'b000101, 6);
        chk("l1_first", 32'(n_match[1] - base), 32'd1);
        send_lane(1, 16'b0010100101, 10);
        chk("l1_total", 32'(n_match[1] - base), 32'd3);
        rd_lane = 2'd1;
        tick();
        chk("l1_rd_cnt", 32'(rd_cnt), 32'd3);

        // All lanes requesting: strict 0,1,2,3 rotation
        do_reset();
        req = '1;
        for (int c = 0; c < 8; c++) begin
            sym = NLANES'($urandom);
            #1;
            chk("rr_order", 32'(gnt), 32'(1 << (c % NLANES)));
            tick();
        end
        req = '0;

        // Saturation: lane 3, five patterns
        do_reset();
        base = n_mv;
        rd_lane = 2'd3;
        for (int p = 0; p < 5; p++) send_lane(3, 16'b00101, 5);
        tick();
        chk("sat_pulses", 32'(n_mv - base), 32'd5);
        chk("sat_rd_cnt", 32'(rd_cnt), 32'(CMAX));

        // clr while lane 0 is at BBCB
        do_reset();
        send_lane(0, 16'b0010, 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        base = n_match[0];
        send_lane(0, 16'b1, 1);
        chk("clr_nomatch", 32'(n_match[0] - base), 32'd0);

        // Reset while lane 0 is at BBCB, counters non-zero beforehand
        do_reset();
        send_lane(0, 16'b00101, 5);
        send_lane(0, 16'b0010, 4);
        rst = 1'b0;
        req = 4'b0001;
        sym[0] = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        tick();
        rst = 1'b1;
        req = '0;
        for (int l = 0; l < NLANES; l++) begin
            rd_lane = LANE_W'(l);
            tick();
            chk("rst_cnt", 32'(rd_cnt), 32'd0);
        end
        base = n_match[0];
        send_lane(0, 16'b1, 1);
        chk("rst_nomatch", 32'(n_match[0] - base), 32'd0);

        // en low for 3 cycles at BBCB, then C completes the match
        do_reset();
        send_lane(0, 16'b0010, 4);
        en = 1'b0;
        req = 4'b0001;
        sym[0] = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        en = 1'b1;
        base = n_match[0];
        send_lane(0, 16'b1, 1);
        chk("en_resume", 32'(n_match[0] - base), 32'd1);

        // Randomized traffic: requesters hold req/sym until granted
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NLANES; i++) begin
                if (!req[i] || exp_gnt[i]) begin
                    req[i] = ($urandom_range(0, 3) != 0);
                    sym[i] = 1'($urandom_range(0, 1));
                end
            end
            en      = ($urandom_range(0, 9) != 0);
            clr     = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 99) != 0);
            rd_lane = LANE_W'($urandom_range(0, NLANES - 1));
            tick();
            for (int i = 0; i < NLANES; i++) begin
                if (!rst) begin
                    wait_cyc[i] = 0;
                end else if (exp_gnt[i]) begin
                    chk("fair_wait", 32'(wait_cyc[i] < NLANES), 32'd1);
                    wait_cyc[i] = 0;
                end else if (req[i] && en && !clr) begin
                    wait_cyc[i]++;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_det_sched.md
Name: pattern_det_sched

Overview:
- Round-robin scheduler that time-shares one BBCBC pattern-detect engine across NLANES independent vehicle-sensor lanes.
- Each lane presents one symbol at a time: B = 0, C = 1.
- Per-lane match progress lives in a small state array, so each lane detects BBCBC in its own stream even though symbols interleave.
- Match events are reported with a lane ID; per-lane saturating match counters are readable by lane index.

Parameters:
- NLANES, 4, number of requesting lanes (2..8).
- LANE_W, 2, width of lane index; must equal ceil(log2(NLANES)).
- CNT_W, 8, width of each per-lane match counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  global enable; 0 forces gnt = 0, and state and pointer hold.
- clr  in  1  synchronous clear of all lane states and counters; rst has priority.
- req  in  NLANES  per-lane symbol-valid.
- sym  in  NLANES  per-lane symbol; 0 = B, 1 = C.
- gnt  out  NLANES  one-hot grant, combinational from req, en and the RR pointer.
- match_vld  out  1  registered one-cycle pulse: a lane just completed BBCBC.
- match_lane  out  LANE_W  lane that matched; valid when match_vld = 1.
- rd_lane  in  LANE_W  counter read select.
- rd_cnt  out  CNT_W  registered match count of rd_lane, 1-cycle read latency.

Behaviour:
- Reset (rst = 0 at clk edge):
  - Lane states = S0, counters = 0, RR pointer = 0.
  - match_vld = 0, match_lane = 0, rd_cnt = 0.
- Handshake: a lane's symbol is consumed in a cycle iff req[i] & gnt[i]. Requesters hold req and sym until granted.
- Grant:
  - gnt has at most one bit set.
  - Search starts at the RR pointer and wraps modulo NLANES; the first lane with req set is granted.
  - gnt = 0 when en = 0, clr = 1, or req = 0.
  - A non-granted lane keeps req; it is granted within NLANES cycles (fairness bound).
- Pointer: after a grant to lane k, pointer = (k+1) mod NLANES. Pointer unchanged when no grant.
- Per-lane detector states: S0 idle, S1 "B", S2 "BB", S3 "BBC", S4 "BBCB". Only the granted lane's state updates.
  - S0: B → S1; C → S0.
  - S1: B → S2; C → S0.
  - S2: B → S2; C → S3.
  - S3: B → S4; C → S0.
  - S4: B → S2; C → S0 and match.
- Overlap: after a match the lane restarts from S0, so BBCBCBBCBC yields 2 matches.
- Match timing: for a match on the symbol consumed in cycle t:
  - match_vld = 1 and match_lane = k in cycle t+1;
  - counter[k] increments at the same edge;
  - otherwise match_vld = 0 next cycle.
- Counters: saturate at 2^CNT_W − 1; no wrap.
- Read port: rd_cnt registers counter[rd_lane] each cycle. It shows the value before any same-edge increment. rd_lane values ≥ NLANES return 0.
- clr = 1:
  - Next edge sets all lane states to S0 and all counters to 0; pointer is kept.
  - match_vld = 0 next cycle, even if a match was in flight.
- Mid-operation reset: all state is discarded. A partially seen pattern (e.g. lane at S4) does not complete after reset.
- en = 0 mid-pattern: lane states are frozen. The pattern resumes when en returns to 1.
- Illegal state encodings (5..7) in a lane recover to S0 on that lane's next grant, with no match.

Test Plan:
- Single lane 0, req held, sym = 0,0,1,0,1 over 5 cycles → match_vld = 1, match_lane = 0 in the cycle after the 5th symbol; rd_lane = 0 gives rd_cnt = 1.
- Lanes 0 and 2 both request continuously, interleaving BBCBC each → gnt alternates 0001/0100. Exactly one match per lane, lane 0 first; counters 0 and 2 = 1, counters 1 and 3 = 0.
- Lane 1 sends BBBCBC, then BBCBCBBCBC → 1 match, then 2 matches. Final counter[1] = 3, confirming the S2 self-loop and the restart from S0.
- All 4 lanes request every cycle → each lane granted exactly once per 4 cycles in order 0,1,2,3,0,…. No lane waits more than 4 cycles.
- Counter saturation with CNT_W = 2: lane 3 completes 5 patterns → rd_cnt stays at 3 after the 3rd match, while match_vld still pulses 5 times.
- Lane 0 is at S4 (BBCB consumed):
  - Assert clr for 1 cycle, then send C → no match.
  - Repeat with rst = 0 for 1 cycle → no match, gnt = 0 during reset, all counters read 0.
  - en = 0 for 3 cycles at S4, then send C → match.
